multu_datapath: RTL and testbench
=================================

MULTU_DATAPATH -- requirements
Module: multu_datapath

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; clock port is clk, reset port is Reset.
REQ-002 The port list SHALL be as follows:
  clk           input   1   rising-edge clock
  Reset         input   1   synchronous active-high reset
  Load          input   1   capture operands into the internal registers
  Multiplicand  input   32  unsigned multiplicand operand
  Multiplier    input   32  unsigned multiplier operand
  Addu_ctrl     input   6   adder operation select from the control stage
  SRL_ctrl      input   1   shift-right enable from the control stage
  W_ctrl        input   1   write the adder result into the product upper half
  LSB           output  1   bit 0 of the product register, fed back to control
  Product       output  64  product register contents
REQ-003 Constant ADDU_FUNCT SHALL equal 6'b001001 and means "add multiplicand".
REQ-004 Any other Addu_ctrl value SHALL mean "add zero".

Function
REQ-005 Internal state SHALL be: MCND (32b), PROD (64b) and carry bit C (1b).
REQ-006 Adder: SUM[32:0] = PROD[63:32] + (Addu_ctrl==ADDU_FUNCT ? MCND : 0); unsigned, 33-bit, no truncation.
REQ-007 Load=1: MCND<=Multiplicand; PROD<={32'h0, Multiplier}; C<=0.
REQ-008 Load SHALL override W_ctrl and SRL_ctrl in the same cycle.
REQ-009 W_ctrl=1, SRL_ctrl=0, Load=0: {C, PROD[63:32]}<=SUM; PROD[31:0] held.
REQ-010 SRL_ctrl=1, W_ctrl=0, Load=0: PROD<={C, PROD[63:1]}; C<=0.
REQ-011 W_ctrl=1, SRL_ctrl=1, Load=0 (one-cycle add-and-shift): PROD<={SUM[32:0], PROD[31:1]}; C<=0.
REQ-012 W_ctrl=0, SRL_ctrl=0, Load=0: all state SHALL hold.
REQ-013 LSB SHALL equal PROD[0] and Product SHALL equal PROD, both driven from registers with no combinational path from the inputs.
REQ-014 Timing: control decisions made on LSB in cycle n take effect at edge n+1, and the new LSB is visible in the same cycle after that edge (zero-latency feedback for the 32-iteration loop).
REQ-015 After Load followed by 32 add-and-shift cycles (Addu_ctrl=ADDU_FUNCT exactly when LSB=1), Product SHALL equal the full 64-bit unsigned product.
REQ-016 Further shift cycles past 32 SHALL continue shifting with no protection; this is the control stage's responsibility.
REQ-017 MCND SHALL change only on Load or Reset.

Reset
REQ-018 Reset=1 at a rising edge SHALL clear MCND, PROD and C to 0, giving Product=0 and LSB=0.
REQ-019 Reset SHALL take priority over Load, W_ctrl and SRL_ctrl.
REQ-020 Reset mid-multiplication SHALL abort the operation with no residual state.
REQ-021 No state SHALL change on any clk edge without Reset, Load, W_ctrl or SRL_ctrl asserted.

Structure
REQ-022 ADDU_FUNCT, operand width (32) and product width (64) SHALL live in a shared package used by the control stage and this block.
REQ-023 The 33-bit unsigned adder (a, b -> {carry, sum}) SHALL be one sub-module, addu32; all registers SHALL stay in multu_datapath.

Verification
REQ-024 Reset: Reset=1 for 1 cycle after arbitrary state -> Product=64'h0, LSB=0.
REQ-025 Load: Multiplicand=3, Multiplier=5 -> next cycle Product=64'h0000_0000_0000_0005, LSB=1; then 32 add-and-shift cycles driven per LSB -> Product=64'd15.
REQ-026 Carry path: 32'hFFFF_FFFF x 32'hFFFF_FFFF via 32 driven cycles -> Product=64'hFFFF_FFFE_0000_0001.
REQ-027 Non-add op: after Load(7,2), W_ctrl=1 with Addu_ctrl=6'b000000 -> upper half stays 0; with SRL_ctrl=1 only -> Product=1, LSB=1.
REQ-028 Priority: Load=1 together with W_ctrl=1 and SRL_ctrl=1 -> operands loaded unmodified; Reset=1 together with Load=1 -> Product=0.
REQ-029 Mid-run reset: Reset asserted at iteration 10 of 3x5 -> Product=0 the next cycle; a fresh Load(6,7) plus 32 cycles -> Product=42.

Source files
------------

// File: rtl/multu_datapath_pkg.sv
// Shared definitions for the unsigned multiply unit (control stage and datapath).
// Holds the operand/product widths, the adder function code and the decoded
// datapath operation type used by multu_datapath.
package multu_datapath_pkg;

    localparam int unsigned OPERAND_W = 32;
    localparam int unsigned PRODUCT_W = 64;

    // Addu_ctrl code meaning "add multiplicand"; every other code adds zero.
    localparam logic [5:0] ADDU_FUNCT = 6'b001001;

    // Datapath operation selected by W_ctrl/SRL_ctrl when Load is low.
    typedef enum logic [1:0] {
        OP_HOLD,
        OP_WRITE,
        OP_SHIFT,
        OP_ADDSHIFT
    } dp_op_e;

    function automatic dp_op_e decode_op(input logic w, input logic srl);
        dp_op_e op;
        op = OP_HOLD;
        case ({w, srl})
            2'b10:   op = OP_WRITE;
            2'b01:   op = OP_SHIFT;
            2'b11:   op = OP_ADDSHIFT;
            default: op = OP_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multu_datapath_addu32.sv
// addu32: 32-bit unsigned adder with carry out.
// Ports:
//   a, b   operands (OPERAND_W bits)
//   sum    low OPERAND_W bits of a + b
//   carry  carry out of the top bit
module addu32
    import multu_datapath_pkg::*;
(
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    output logic [OPERAND_W-1:0] sum,
    output logic                 carry
);

    always_comb begin
        {carry, sum} = {1'b0, a} + {1'b0, b};
    end

endmodule

// File: rtl/multu_datapath.sv
// multu_datapath: shift-add datapath for a 32x32 -> 64 unsigned multiplier.
// The control stage watches LSB and drives Addu_ctrl/W_ctrl/SRL_ctrl each
// cycle; 32 add-and-shift cycles after Load leave the product in Product.
// Ports:
//   clk, Reset    clock and synchronous active-high reset
//   Load          capture Multiplicand and Multiplier (beats W_ctrl/SRL_ctrl)
//   Multiplicand  multiplicand operand
//   Multiplier    multiplier operand (loaded into the low product half)
//   Addu_ctrl     ADDU_FUNCT adds the multiplicand, anything else adds zero
//   SRL_ctrl      shift the product (with carry) right by one
//   W_ctrl        write the adder result into the upper product half
//   LSB           PROD[0], registered, for the control stage
//   Product       product register
module multu_datapath
    import multu_datapath_pkg::*;
(
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 Load,
    input  logic [OPERAND_W-1:0] Multiplicand,
    input  logic [OPERAND_W-1:0] Multiplier,
    input  logic [5:0]           Addu_ctrl,
    input  logic                 SRL_ctrl,
    input  logic                 W_ctrl,
    output logic                 LSB,
    output logic [PRODUCT_W-1:0] Product
);

    logic [OPERAND_W-1:0] mcnd;
    logic [PRODUCT_W-1:0] prod;
    logic                 carry_bit;

    logic [OPERAND_W-1:0] addend;
    logic [OPERAND_W-1:0] sum_lo;
    logic                 sum_carry;
    dp_op_e               op;

    always_comb begin
        addend = (Addu_ctrl == ADDU_FUNCT) ? mcnd : '0;
        op     = decode_op(W_ctrl, SRL_ctrl);
    end

    addu32 u_addu32 (
        .a     (prod[PRODUCT_W-1:OPERAND_W]),
        .b     (addend),
        .sum   (sum_lo),
        .carry (sum_carry)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            mcnd      <= '0;
            prod      <= '0;
            carry_bit <= 1'b0;
        end else if (Load) begin
            mcnd      <= Multiplicand;
            prod      <= {{OPERAND_W{1'b0}}, Multiplier};
            carry_bit <= 1'b0;
        end else begin
            case (op)
                OP_WRITE: begin
                    {carry_bit, prod[PRODUCT_W-1:OPERAND_W]} <= {sum_carry, sum_lo};
                end
                OP_SHIFT: begin
                    prod      <= {carry_bit, prod[PRODUCT_W-1:1]};
                    carry_bit <= 1'b0;
                end
                OP_ADDSHIFT: begin
                    // Add and shift fused: the 33-bit sum lands directly in
                    // PROD[63:31], so the carry never needs to be parked in C.
                    prod      <= {sum_carry, sum_lo, prod[OPERAND_W-1:1]};
                    carry_bit <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        LSB     = prod[0];
        Product = prod;
    end

endmodule

// File: tb/tb_multu_datapath.sv
module tb_multu_datapath;
    import multu_datapath_pkg::*;

    logic        clk = 1'b0;
    logic        Reset;
    logic        Load;
    logic [31:0] Multiplicand;
    logic [31:0] Multiplier;
    logic [5:0]  Addu_ctrl;
    logic        SRL_ctrl;
    logic        W_ctrl;
    logic        LSB;
    logic [63:0] Product;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multu_datapath dut (
        .clk          (clk),
        .Reset        (Reset),
        .Load         (Load),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .Addu_ctrl    (Addu_ctrl),
        .SRL_ctrl     (SRL_ctrl),
        .W_ctrl       (W_ctrl),
        .LSB          (LSB),
        .Product      (Product)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        load;
        logic [31:0] mcnd;
        logic [31:0] mplr;
        logic [5:0]  addu;
        logic        srl;
        logic        w;
        logic [63:0] exp_p;
        logic        exp_lsb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic rst, input logic load,
                                input logic [31:0] mcnd, input logic [31:0] mplr,
                                input logic [5:0] addu, input logic srl, input logic w,
                                input logic [63:0] exp_p, input logic exp_lsb);
        vec_t v;
        v.name = name; v.rst = rst; v.load = load; v.mcnd = mcnd; v.mplr = mplr;
        v.addu = addu; v.srl = srl; v.w = w; v.exp_p = exp_p; v.exp_lsb = exp_lsb;
        return v;
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic load, input logic [31:0] mcnd,
                         input logic [31:0] mplr, input logic [5:0] addu,
                         input logic srl, input logic w);
        @(negedge clk);
        Reset = rst; Load = load; Multiplicand = mcnd; Multiplier = mplr;
        Addu_ctrl = addu; SRL_ctrl = srl; W_ctrl = w;
        @(posedge clk);
        #1;
    endtask

    // One add-and-shift iteration, decided on the current LSB.
    task automatic step();
        logic [5:0] a;
        @(negedge clk);
        a = LSB ? ADDU_FUNCT : 6'b000000;
        Reset = 1'b0; Load = 1'b0; W_ctrl = 1'b1; SRL_ctrl = 1'b1; Addu_ctrl = a;
        @(posedge clk);
        #1;
    endtask

    task automatic multiply(input string name, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        exp = {32'h0, a} * {32'h0, b};
        drive(1'b0, 1'b1, a, b, 6'b0, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 32; i++) step();
        check64(name, Product, exp);
    endtask

    initial begin
        Reset = 1'b1; Load = 1'b0; Multiplicand = '0; Multiplier = '0;
        Addu_ctrl = '0; SRL_ctrl = 1'b0; W_ctrl = 1'b0;

        //                 name          rst   load  mcnd          mplr          addu        srl   w     exp_p                  lsb
        vecs.push_back(mk("reset",       1'b1, 1'b0, 32'h0,        32'h0,        6'b0,       1'b0, 1'b0, 64'h0,                 1'b0));
        vecs.push_back(mk("load35",      1'b0, 1'b1, 32'd3,        32'd5,        6'b0,       1'b0, 1'b0, 64'h5,                 1'b1));
        vecs.push_back(mk("write_add",   1'b0, 1'b0, 32'h0,        32'h0,        ADDU_FUNCT, 1'b0, 1'b1, 64'h0000_0003_0000_0005, 1'b1));
        vecs.push_back(mk("shift",       1'b0, 1'b0, 32'h0,        32'h0,        6'b0,       1'b1, 1'b0, 64'h0000_0001_8000_0002, 1'b0));
        vecs.push_back(mk("hold",        1'b0, 1'b0, 32'hDEAD,     32'hBEEF,     ADDU_FUNCT, 1'b0, 1'b0, 64'h0000_0001_8000_0002, 1'b0));
        vecs.push_back(mk("load_prio",   1'b0, 1'b1, 32'd7,        32'd2,        ADDU_FUNCT, 1'b1, 1'b1, 64'h2,                 1'b0));
        vecs.push_back(mk("write_zero",  1'b0, 1'b0, 32'h0,        32'h0,        6'b000000,  1'b0, 1'b1, 64'h2,                 1'b0));
        vecs.push_back(mk("shift_only",  1'b0, 1'b0, 32'h0,        32'h0,        6'b0,       1'b1, 1'b0, 64'h1,                 1'b1));
        vecs.push_back(mk("reset_prio",  1'b1, 1'b1, 32'd9,        32'd9,        ADDU_FUNCT, 1'b1, 1'b1, 64'h0,                 1'b0));
        vecs.push_back(mk("load_ff",     1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'b0,     1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b1));
        vecs.push_back(mk("write_ff1",   1'b0, 1'b0, 32'h0,        32'h0,        ADDU_FUNCT, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1));
        vecs.push_back(mk("write_carry", 1'b0, 1'b0, 32'h0,        32'h0,        ADDU_FUNCT, 1'b0, 1'b1, 64'hFFFF_FFFE_FFFF_FFFF, 1'b1));
        vecs.push_back(mk("shift_carry", 1'b0, 1'b0, 32'h0,        32'h0,        6'b0,       1'b1, 1'b0, 64'hFFFF_FFFF_7FFF_FFFF, 1'b1));
        vecs.push_back(mk("shift_c_clr", 1'b0, 1'b0, 32'h0,        32'h0,        6'b0,       1'b1, 1'b0, 64'h7FFF_FFFF_BFFF_FFFF, 1'b1));
        vecs.push_back(mk("write_c2",    1'b0, 1'b0, 32'h0,        32'h0,        ADDU_FUNCT, 1'b0, 1'b1, 64'h7FFF_FFFE_BFFF_FFFF, 1'b1));
        vecs.push_back(mk("addshift_c",  1'b0, 1'b0, 32'h0,        32'h0,        ADDU_FUNCT, 1'b1, 1'b1, 64'hBFFF_FFFE_DFFF_FFFF, 1'b1));
        vecs.push_back(mk("shift_after", 1'b0, 1'b0, 32'h0,        32'h0,        6'b0,       1'b1, 1'b0, 64'h5FFF_FFFF_6FFF_FFFF, 1'b1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].load, vecs[i].mcnd, vecs[i].mplr,
                  vecs[i].addu, vecs[i].srl, vecs[i].w);
            check64({vecs[i].name, "_prod"}, Product, vecs[i].exp_p);
            check1({vecs[i].name, "_lsb"}, LSB, vecs[i].exp_lsb);
        end

        // Full 32-iteration multiplies.
        multiply("mul_3x5", 32'd3, 32'd5);
        check64("mul_3x5_const", Product, 64'd15);
        multiply("mul_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check64("mul_ffxff_const", Product, 64'hFFFF_FFFE_0000_0001);
        multiply("mul_mixed", 32'h1234_5678, 32'h9ABC_DEF0);
        multiply("mul_zero", 32'h0, 32'hFFFF_FFFF);

        // Shifting past 32 iterations is unprotected: 15 -> 7.
        multiply("mul_3x5_again", 32'd3, 32'd5);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 6'b0, 1'b1, 1'b0);
        check64("overshift", Product, 64'd7);

        // Reset at iteration 10 of 3x5 aborts; then 6x7 from clean state.
        drive(1'b0, 1'b1, 32'd3, 32'd5, 6'b0, 1'b0, 1'b0);
        check64("mid_load", Product, 64'd5);
        for (int unsigned i = 0; i < 10; i++) step();
        drive(1'b1, 1'b0, 32'h0, 32'h0, ADDU_FUNCT, 1'b1, 1'b1);
        check64("mid_reset_prod", Product, 64'h0);
        check1("mid_reset_lsb", LSB, 1'b0);
        multiply("mul_6x7", 32'd6, 32'd7);
        check64("mul_6x7_const", Product, 64'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
